// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA raster timing generator. It produces the pixel
//             and line counters, sync, blanking, data-enable and start strobes.
//  Options  : define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 1024,
  parameter int unsigned H_FP        = 24,
  parameter int unsigned H_SYNC      = 136,
  parameter int unsigned H_BP        = 160,
  parameter int unsigned V_ACTIVE    = 768,
  parameter int unsigned V_FP        = 3,
  parameter int unsigned V_SYNC      = 6,
  parameter int unsigned V_BP        = 29,
  parameter int unsigned SYNC_POS    = 1,
  parameter int unsigned CNT_W       = 11,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int unsigned c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned c_hs_start = H_ACTIVE + H_FP;
  localparam int unsigned c_hs_end   = c_hs_start + H_SYNC;
  localparam int unsigned c_vs_start = V_ACTIVE + V_FP;
  localparam int unsigned c_vs_end   = c_vs_start + V_SYNC;

  localparam logic [CNT_W-1:0] c_h_max = CNT_W'(c_h_total - 1);
  localparam logic [CNT_W-1:0] c_v_max = CNT_W'(c_v_total - 1);
  localparam logic c_sync_idle = (SYNC_POS == 0) ? 1'b1 : 1'b0;

  generate
    if (64'(c_h_total) > (64'd1 << CNT_W)) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL %0d does not fit in CNT_W=%0d", c_h_total, CNT_W);
    end
    if (64'(c_v_total) > (64'd1 << CNT_W)) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL %0d does not fit in CNT_W=%0d", c_v_total, CNT_W);
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
      $error("vga_timing_gen: porch and sync widths must be non-zero");
    end
    if (FRAME_CNT_W == 0) begin : g_bad_frame_cnt_w
      $error("vga_timing_gen: FRAME_CNT_W must be non-zero");
    end
  endgenerate

  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_hblnk;
  logic             r_vblnk;
  logic             r_de;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [CNT_W-1:0] w_hcount_nxt;
  logic [CNT_W-1:0] w_vcount_nxt;
  logic [31:0]      w_h32;
  logic [31:0]      w_v32;
  logic             w_hblnk_nxt;
  logic             w_vblnk_nxt;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_line_nxt;
  logic             w_frame_nxt;

  // Flags are derived from the next counter values so they line up with the
  // counters they are registered alongside.
  always_comb begin
    w_h_wrap     = (r_hcount == c_h_max);
    w_v_wrap     = (r_vcount == c_v_max);
    w_hcount_nxt = w_h_wrap ? '0 : r_hcount + CNT_W'(1);
    w_vcount_nxt = r_vcount;
    if (w_h_wrap) begin
      w_vcount_nxt = w_v_wrap ? '0 : r_vcount + CNT_W'(1);
    end
    w_h32       = 32'(w_hcount_nxt);
    w_v32       = 32'(w_vcount_nxt);
    w_hblnk_nxt = (w_h32 >= H_ACTIVE);
    w_vblnk_nxt = (w_v32 >= V_ACTIVE);
    w_hs_act    = (w_h32 >= c_hs_start) && (w_h32 < c_hs_end);
    w_vs_act    = (w_v32 >= c_vs_start) && (w_v32 < c_vs_end);
    w_line_nxt  = (w_hcount_nxt == '0);
    w_frame_nxt = w_line_nxt && (w_vcount_nxt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= c_sync_idle;
      r_vsync       <= c_sync_idle;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (en) begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_hsync       <= w_hs_act ^ c_sync_idle;
      r_vsync       <= w_vs_act ^ c_sync_idle;
      r_hblnk       <= w_hblnk_nxt;
      r_vblnk       <= w_vblnk_nxt;
      r_de          <= !w_hblnk_nxt && !w_vblnk_nxt;
      r_line_start  <= w_line_nxt;
      r_frame_start <= w_frame_nxt;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  // Counts completed frames, stepping as the raster wraps back to (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (en && w_frame_nxt) begin
      r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hblnk       = r_hblnk;
  assign vblnk       = r_vblnk;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire
